// File: rtl/bus_arbiter.sv
// Single-port memory arbiter for the ToruMIPS core: one external bus shared by
// instruction fetch and MEM-stage data access, with wait-state timeout and stall vector.
module bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,

    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,

    output logic              bus_cyc_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,

    output logic [5:0]        stall_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE,
        IF_ACC,
        MEM_ACC
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    localparam logic [5:0] STALL_NONE  = 6'b000000;
    localparam logic [5:0] STALL_FETCH = 6'b000111;
    localparam logic [5:0] STALL_DATA  = 6'b011111;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       mem_go;
    logic       if_go;
    logic       timeout;

    // A requester whose ack is on the outputs this cycle is not eligible, so a
    // request still held high through its ack cycle is not issued a second time.
    assign mem_go = mem_req_i && !mem_ack_o;
    assign if_go  = if_req_i  && !if_ack_o;

    // wait_cnt counts completed wait cycles; an ack arriving in the same cycle
    // the count has reached the limit still wins over the abort.
    assign timeout = !bus_ack_i && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            if_data_o   <= '0;
            if_ack_o    <= 1'b0;
            mem_rdata_o <= '0;
            mem_ack_o   <= 1'b0;
            bus_cyc_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            err_o       <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every
            // branch below sees the pre-edge values of the outputs it tests.
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
            err_o       <= 1'b0;
            if_data_o   <= '0;
            mem_rdata_o <= '0;

            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (mem_go) begin
                        bus_cyc_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_sel_o   <= mem_sel_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= mem_wdata_i;
                        state       <= MEM_ACC;
                    end else if (if_go) begin
                        bus_cyc_o  <= 1'b1;
                        bus_we_o   <= 1'b0;
                        bus_sel_o  <= 4'b1111;
                        bus_addr_o <= if_addr_i;
                        state      <= IF_ACC;
                    end
                end

                IF_ACC, MEM_ACC: begin
                    if (bus_ack_i || timeout) begin
                        bus_cyc_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                        bus_sel_o <= '0;
                        err_o     <= !bus_ack_i;
                        state     <= IDLE;
                        if (state == MEM_ACC) begin
                            mem_ack_o   <= 1'b1;
                            mem_rdata_o <= bus_ack_i ? bus_rdata_i : '0;
                        end else begin
                            if_ack_o  <= 1'b1;
                            if_data_o <= bus_ack_i ? bus_rdata_i : '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // A pending data access also freezes the fetch-side stages.
    always_comb begin
        // NOTE: the default assignment first keeps this block free of latches.
        stall_o = STALL_NONE;
        if (!rst) begin
            if (mem_go) begin
                stall_o = STALL_DATA;
            end else if (if_go) begin
                stall_o = STALL_FETCH;
            end
        end
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Single-port memory arbiter for the ToruMIPS core. It shares one external memory bus between instruction fetch (PC/IF) and the MEM-stage data access. It sequences each bus transaction with a request/acknowledge handshake and a wait-state timeout. It drives the 6-bit pipeline stall vector so that the stages upstream of a waiting requester hold.

## Interface
Parameters:
- ADDR_W, 32, address width (matches RegBus)
- DATA_W, 32, data width
- MAX_WAIT, 16, wait cycles allowed per access before abort (1..255)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request; held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_data_o  out  DATA_W  fetched instruction; valid while if_ack_o=1
- if_ack_o  out  1  one-cycle fetch completion pulse
- mem_req_i  in  1  data request; held until mem_ack_o
- mem_we_i  in  1  1=write, 0=read
- mem_sel_i  in  4  byte enables
- mem_addr_i  in  ADDR_W  data address
- mem_wdata_i  in  DATA_W  store data
- mem_rdata_o  out  DATA_W  load data; valid while mem_ack_o=1
- mem_ack_o  out  1  one-cycle data completion pulse
- bus_cyc_o  out  1  bus cycle active
- bus_we_o  out  1  bus write strobe
- bus_sel_o  out  4  bus byte enables (4'b1111 for fetch)
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  DATA_W  bus write data
- bus_rdata_i  in  DATA_W  bus read data, sampled when bus_ack_i=1
- bus_ack_i  in  1  slave completion, one cycle
- stall_o  out  6  stall vector: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
- err_o  out  1  one-cycle pulse on timeout abort

## Operation
- FSM states: IDLE, IF_ACC, MEM_ACC. Reset state is IDLE.
- IDLE:
  - An eligible mem_req_i registers the address, we, sel and wdata into the bus outputs. It asserts bus_cyc_o and moves to MEM_ACC.
  - Otherwise, an eligible if_req_i registers if_addr_i with sel=4'b1111 and we=0, and moves to IF_ACC.
  - A requester is eligible only if its ack_o is 0 in that cycle. This prevents re-issuing a completed access.
- Priority: data access always wins over fetch, because it belongs to the older instruction. There is no round-robin.
- IF_ACC / MEM_ACC:
  - Bus outputs are held stable.
  - On bus_ack_i:
    - register bus_rdata_i into the matching *_data_o;
    - pulse the matching ack_o for the next cycle;
    - drop bus_cyc_o, bus_we_o and bus_sel_o;
    - return to IDLE.
  - Writes still complete via ack, and rdata_o is updated with bus_rdata_i regardless.
- Wait counter: 8 bits, cleared on entering an ACC state, incremented every ACC cycle without bus_ack_i.
- Timeout: if the count reaches MAX_WAIT without ack, abort the access:
  - drop bus_cyc_o;
  - pulse the matching ack_o with data 0 and pulse err_o, both in the next cycle;
  - return to IDLE.
- bus_ack_i is ignored in IDLE.
- Stall vector is combinational:
  - mem_req_i && !mem_ack_o → 6'b011111;
  - else if_req_i && !if_ack_o → 6'b000111;
  - else 6'b000000.
  - A pending data access therefore freezes the fetch-side stall bits too.
- Reset outputs: all *_o = 0, stall_o = 0, FSM IDLE, counter 0.

## Timing
- Latency, zero-wait slave: request seen in IDLE at cycle 0 → bus_cyc_o=1 in cycle 1 → bus_ack_i in cycle 1 → ack_o=1 and data valid in cycle 2. Minimum 2 cycles, plus N slave wait states.
- ack_o, data_o and err_o are registered and last exactly one cycle.
- The requester may drop or change its request in the ack cycle. stall_o deasserts in that same cycle, so the pipeline advances on the following edge.
- Back-to-back accesses:
  - After returning to IDLE, a new access can start in the ack cycle, but only for the other requester.
  - The same requester restarts one cycle later.
- Both requests in the same IDLE cycle: MEM is served first. IF is served in the cycle after mem_ack_o, provided if_req_i is still high.
- Async rst mid-access: bus_cyc_o drops immediately and no ack is generated. The aborted transaction is lost.
- Timeout boundary: with MAX_WAIT=16, a slave that acks in the 16th wait cycle completes normally; one cycle later it aborts. bus_ack_i coinciding with the timeout is treated as success.

## Test plan
- Fetch, zero-wait slave: if_req_i=1, addr 0x00000004, slave returns 0x3C010101 → bus_cyc_o in cycle 1, if_ack_o and if_data_o=0x3C010101 in cycle 2, stall_o=6'b000111 in cycles 0–1.
- Simultaneous requests: both raised in cycle 0, mem store 0x11223344 to 0x100 with sel 4'b1111, slave 2 wait states:
  - bus_we_o=1 first, mem_ack_o in cycle 4;
  - fetch starts in cycle 4, if_ack_o in cycle 6 (zero-wait);
  - stall_o=6'b011111 in cycles 0–3.
- Byte load: mem_sel_i=4'b0010 → bus_sel_o=4'b0010, bus_we_o=0, mem_rdata_o equals bus_rdata_i captured on ack.
- Timeout, MAX_WAIT=16: slave never acks → err_o and mem_ack_o pulse with mem_rdata_o=0 after 16 wait cycles, then bus_cyc_o=0 and FSM back in IDLE. A subsequent fetch succeeds.
- Async reset: assert rst in the middle of a 5-wait-state access → bus_cyc_o, stall_o and all acks go 0 without a clock edge. After release, a new fetch completes normally.
- No re-issue: hold if_req_i high through the ack cycle → exactly one bus cycle per ack, with the second access starting one cycle after the ack.
